// File: rtl/slow_clock_sync.sv
// Recovers edge strobes, half-period and a lock indication from a divided clock sampled as async data.
// Define SLOW_CLOCK_SYNC_GLITCH_FILTER_EN to suppress single-cycle pulses on slow_in (adds one cycle of latency).
module slow_clock_sync #(
    parameter int EXPECT_HALF = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             slow_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             locked,
    output logic             lost_lock
);

    localparam int MC_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             stable;
    logic             edge_now;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] meas;
    logic [MC_W-1:0]  mcnt_q, mcnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             rise_q, fall_q, locked_q, lost_q, lost_d;
    logic             match, timeout;

`ifdef SLOW_CLOCK_SYNC_GLITCH_FILTER_EN
    logic s2p_q;
    // s2 must hold the same value for two cycles before it is accepted as a new level
    assign stable = (s2_q == s2p_q);
`else
    assign stable = 1'b1;
`endif

    assign edge_now = stable & (s2_q ^ s3_q);
    assign meas     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign cnt_d    = edge_now ? '0 : meas;
    assign match    = (meas == CNT_W'(EXPECT_HALF));
    assign timeout  = ({1'b0, meas} > (CNT_W+1)'(2 * EXPECT_HALF));

    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        half_d  = half_q;
        lost_d  = 1'b0;
        case (state_q)
            UNLOCKED: begin
                // first edge only opens the measurement window
                if (edge_now) begin
                    state_d = ACQUIRE;
                    mcnt_d  = '0;
                end
            end
            ACQUIRE: begin
                if (edge_now) begin
                    half_d = meas;
                    if (match) begin
                        if (mcnt_q == MC_W'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                            mcnt_d  = '0;
                        end else begin
                            mcnt_d = mcnt_q + MC_W'(1);
                        end
                    end else begin
                        mcnt_d = '0;
                    end
                end else if (timeout) begin
                    state_d = UNLOCKED;
                    mcnt_d  = '0;
                end
            end
            LOCKED: begin
                if (edge_now) begin
                    half_d = meas;
                    if (!match) begin
                        state_d = ACQUIRE;
                        mcnt_d  = '0;
                        lost_d  = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = UNLOCKED;
                    mcnt_d  = '0;
                    lost_d  = 1'b1;
                end
            end
            default: begin
                state_d = UNLOCKED;
                mcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            cnt_q    <= '0;
            mcnt_q   <= '0;
            half_q   <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
            state_q  <= UNLOCKED;
        end else begin
            s1_q     <= slow_in;
            s2_q     <= s1_q;
            if (stable) s3_q <= s2_q;
            cnt_q    <= cnt_d;
            mcnt_q   <= mcnt_d;
            half_q   <= half_d;
            rise_q   <= edge_now & s2_q;
            fall_q   <= edge_now & ~s2_q;
            locked_q <= (state_d == LOCKED);
            lost_q   <= lost_d;
            state_q  <= state_d;
        end
    end

`ifdef SLOW_CLOCK_SYNC_GLITCH_FILTER_EN
    always_ff @(posedge clock_in) begin
        if (reset) s2p_q <= 1'b0;
        else       s2p_q <= s2_q;
    end
`endif

    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign half_period = half_q;
    assign locked      = locked_q;
    assign lost_lock   = lost_q;

endmodule

// File: tb/tb_slow_clock_sync.sv
// Directed bench for slow_clock_sync: reset, divide-by-4 lock, freeze timeout, wrong period, stretch/relock, glitch.
module tb_slow_clock_sync;

    logic       clk = 1'b0;
    logic       reset;
    logic       slow_in;
    logic       rise_pulse, fall_pulse, locked, lost_lock;
    logic [7:0] half_period;

`ifdef SLOW_CLOCK_SYNC_GLITCH_FILTER_EN
    localparam int LAT = 4;
    localparam int GLITCH_EDGES = 0;
`else
    localparam int LAT = 3;
    localparam int GLITCH_EDGES = 2;
`endif

    slow_clock_sync #(.EXPECT_HALF(2), .LOCK_COUNT(4), .CNT_W(8)) dut (
        .clock_in    (clk),
        .reset       (reset),
        .slow_in     (slow_in),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .half_period (half_period),
        .locked      (locked),
        .lost_lock   (lost_lock)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, edges = 0, first_rise = 0, last_rise = 0, last_strobe = 0;
    int lost_n = 0, lost_cyc = 0, lost_edge = 0, lock_edge = 0, lock_rises = 0;
    int exp_int = 0;
    logic locked_prev = 1'b0;
    int t0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle and log strobe / lock activity seen after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rise_pulse || fall_pulse) begin
            edges++;
            last_strobe = cyc;
        end
        if (rise_pulse) begin
            if (exp_int != 0 && last_rise != 0) check("rise_interval", cyc - last_rise, exp_int);
            if (first_rise == 0) first_rise = cyc;
            last_rise = cyc;
        end
        if (lost_lock) begin
            lost_n++;
            lost_cyc  = cyc;
            lost_edge = edges;
        end
        if (locked && !locked_prev) begin
            lock_edge = edges;
            lock_rises++;
        end
        locked_prev = locked;
    endtask

    task automatic clr();
        edges = 0; first_rise = 0; last_rise = 0; lost_n = 0;
        lock_edge = 0; lock_rises = 0;
    endtask

    task automatic drive(input int half, input int n);
        for (int i = 0; i < n; i++) begin
            slow_in = ~slow_in;
            repeat (half) tick();
        end
    endtask

    initial begin
        reset   = 1'b1;
        slow_in = 1'b0;

        // reset held while slow_in toggles
        for (int i = 0; i < 3; i++) begin
            slow_in = ~slow_in;
            tick();
            check("reset_outputs", int'({rise_pulse, fall_pulse, locked, lost_lock, half_period}), 0);
        end
        slow_in = 1'b0;
        tick();
        reset = 1'b0;
        clr();
        repeat (6) tick();
        check("no_strobe_low_after_reset", edges, 0);

        // divide-by-4 source
        clr();
        exp_int = 4;
        t0 = cyc;
        drive(2, 12);
        check("first_rise_latency", first_rise - t0, LAT);
        check("lock_at_edge", lock_edge, 5);
        check("locked_div4", int'(locked), 1);
        check("half_div4", int'(half_period), 2);
        check("no_lost_div4", lost_n, 0);
        check("lock_rises_div4", lock_rises, 1);

        // freeze: timeout five cycles after the last strobe
        lost_n  = 0;
        exp_int = 0;
        repeat (15) tick();
        check("freeze_lost_count", lost_n, 1);
        check("freeze_lost_delay", lost_cyc - last_strobe, 5);
        check("freeze_unlocked", int'(locked), 0);

        // wrong period never locks
        clr();
        exp_int = 6;
        drive(3, 14);
        check("half3_no_lock", lock_rises, 0);
        check("half3_locked", int'(locked), 0);
        check("half3_half", int'(half_period), 3);
        check("half3_no_lost", lost_n, 0);

        // reacquire at divide-by-4
        clr();
        exp_int = 0;
        drive(2, 12);
        check("relock_locked", int'(locked), 1);
        check("relock_half", int'(half_period), 2);
        check("relock_rises", lock_rises, 1);

        // one stretched half-period
        lost_n = 0;
        slow_in = ~slow_in;
        repeat (3) tick();
        drive(2, 10);
        check("stretch_lost_count", lost_n, 1);
        check("stretch_relock_edges", lock_edge - lost_edge, 4);
        check("stretch_locked", int'(locked), 1);
        check("stretch_half", int'(half_period), 2);

        // reset while locked must not report lost lock
        reset = 1'b1;
        tick();
        check("reset_locked_lost", int'({lost_lock, locked}), 0);
        tick();
        check("reset_locked_lost2", int'({lost_lock, locked}), 0);
        reset = 1'b0;

        // single-cycle glitch while low
        slow_in = 1'b0;
        repeat (8) tick();
        clr();
        slow_in = 1'b1;
        tick();
        slow_in = 1'b0;
        repeat (8) tick();
        check("glitch_edges", edges, GLITCH_EDGES);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
